// File: rtl/regfile_write_arbiter.sv
// Write-port sequencer for the register file: zero-sweeps every register after reset
// or on ClearReq, then round-robin arbitrates ALU, load-return and LUT writes.
`timescale 1ns/1ps
module regfile_write_arbiter #(
    parameter int unsigned W = 8,
    parameter int unsigned A = 3
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         ClearReq,
    input  logic         AluReq,
    input  logic [A-1:0] AluAddr,
    input  logic [W-1:0] AluData,
    output logic         AluGnt,
    input  logic         MemReq,
    input  logic [A-1:0] MemAddr,
    input  logic [W-1:0] MemData,
    output logic         MemGnt,
    input  logic         LutReq,
    input  logic [W-1:0] LutData,
    output logic         LutGnt,
    output logic         WriteEn,
    output logic [A-1:0] Waddr,
    output logic [W-1:0] DataIn,
    output logic         Busy,
    output logic [7:0]   StallCnt
);

    localparam int unsigned   SW        = 8;
    localparam logic [A-1:0]  LAST_ADDR = '1;
    localparam logic [SW-1:0] STALL_MAX = '1;

    typedef enum logic {ST_CLEAR, ST_RUN} state_e;

    state_e        state_q, state_d;
    logic [A-1:0]  cnt_q, cnt_d;
    logic [1:0]    ptr_q, ptr_d;
    logic          we_q, we_d;
    logic [A-1:0]  waddr_q, waddr_d;
    logic [W-1:0]  data_q, data_d;
    logic [SW-1:0] stall_q, stall_d;
    logic [2:0]    req_c, gnt_c;

    assign req_c = {LutReq, MemReq, AluReq};

    // Round-robin grant, searched from the pointer; bit 0 = ALU, 1 = MEM, 2 = LUT
    always_comb begin
        gnt_c = '0;
        if (state_q == ST_RUN && !ClearReq) begin
            case (ptr_q)
                2'd1: begin
                    if (MemReq)      gnt_c[1] = 1'b1;
                    else if (LutReq) gnt_c[2] = 1'b1;
                    else if (AluReq) gnt_c[0] = 1'b1;
                end
                2'd2: begin
                    if (LutReq)      gnt_c[2] = 1'b1;
                    else if (AluReq) gnt_c[0] = 1'b1;
                    else if (MemReq) gnt_c[1] = 1'b1;
                end
                default: begin
                    if (AluReq)      gnt_c[0] = 1'b1;
                    else if (MemReq) gnt_c[1] = 1'b1;
                    else if (LutReq) gnt_c[2] = 1'b1;
                end
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        data_d  = data_q;
        stall_d = stall_q;

        if ((|(req_c & ~gnt_c)) && stall_q != STALL_MAX) begin
            stall_d = stall_q + SW'(1);
        end

        case (state_q)
            ST_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                data_d  = '0;
                cnt_d   = cnt_q + A'(1);
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                if (ClearReq) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end else if (gnt_c[0]) begin
                    we_d    = 1'b1;
                    waddr_d = AluAddr;
                    data_d  = AluData;
                    ptr_d   = 2'd1;
                end else if (gnt_c[1]) begin
                    we_d    = 1'b1;
                    waddr_d = MemAddr;
                    data_d  = MemData;
                    ptr_d   = 2'd2;
                end else if (gnt_c[2]) begin
                    we_d    = 1'b1;
                    waddr_d = LAST_ADDR;
                    data_d  = LutData;
                    ptr_d   = 2'd0;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= ST_CLEAR;
            cnt_q   <= '0;
            ptr_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            data_q  <= data_d;
            stall_q <= stall_d;
        end
    end

    assign AluGnt   = gnt_c[0];
    assign MemGnt   = gnt_c[1];
    assign LutGnt   = gnt_c[2];
    assign Busy     = (state_q == ST_CLEAR);
    assign WriteEn  = we_q;
    assign Waddr    = waddr_q;
    assign DataIn   = data_q;
    assign StallCnt = stall_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomised and directed bench for regfile_write_arbiter against a cycle-level
// behavioural model of the sweep / round-robin write-port rules.
`timescale 1ns/1ps
module tb_regfile_write_arbiter;

    localparam int NREG = 8;

    logic       Clk, Reset, ClearReq;
    logic       AluReq, MemReq, LutReq;
    logic [2:0] AluAddr, MemAddr;
    logic [7:0] AluData, MemData, LutData;
    logic       AluGnt, MemGnt, LutGnt;
    logic       WriteEn, Busy;
    logic [2:0] Waddr;
    logic [7:0] DataIn, StallCnt;
    logic [2:0] gnt_v;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int m_busy, m_cnt, m_ptr, m_we, m_waddr, m_data, m_stall;
    int exp_win;

    regfile_write_arbiter #(.W(8), .A(3)) dut (
        .Clk(Clk), .Reset(Reset), .ClearReq(ClearReq),
        .AluReq(AluReq), .AluAddr(AluAddr), .AluData(AluData), .AluGnt(AluGnt),
        .MemReq(MemReq), .MemAddr(MemAddr), .MemData(MemData), .MemGnt(MemGnt),
        .LutReq(LutReq), .LutData(LutData), .LutGnt(LutGnt),
        .WriteEn(WriteEn), .Waddr(Waddr), .DataIn(DataIn),
        .Busy(Busy), .StallCnt(StallCnt)
    );

    assign gnt_v = {LutGnt, MemGnt, AluGnt};

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    function automatic int req_of(input int i);
        case (i)
            0:       return int'(AluReq);
            1:       return int'(MemReq);
            default: return int'(LutReq);
        endcase
    endfunction

    function automatic int model_win();
        if (m_busy != 0 || ClearReq) return -1;
        for (int k = 0; k < 3; k++) begin
            if (req_of((m_ptr + k) % 3) != 0) return (m_ptr + k) % 3;
        end
        return -1;
    endfunction

    function automatic logic [2:0] win_vec(input int w);
        case (w)
            0:       return 3'b001;
            1:       return 3'b010;
            2:       return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

    task automatic model_reset();
        m_busy = 1; m_cnt = 0; m_ptr = 0;
        m_we = 0; m_waddr = 0; m_data = 0; m_stall = 0;
    endtask

    task automatic model_edge(input int win);
        if (((AluReq && win != 0) || (MemReq && win != 1) || (LutReq && win != 2)) && m_stall < 255)
            m_stall++;
        if (m_busy != 0) begin
            m_we = 1; m_waddr = m_cnt; m_data = 0;
            if (m_cnt == NREG - 1) m_busy = 0;
            m_cnt++;
        end else if (ClearReq) begin
            m_busy = 1; m_cnt = 0; m_we = 0;
        end else if (win >= 0) begin
            m_we = 1;
            m_waddr = (win == 0) ? int'(AluAddr) : (win == 1) ? int'(MemAddr) : NREG - 1;
            m_data  = (win == 0) ? int'(AluData) : (win == 1) ? int'(MemData) : int'(LutData);
            m_ptr = (win + 1) % 3;
        end else begin
            m_we = 0;
        end
    endtask

    task automatic at_negedge();
        @(negedge Clk);
        exp_win = model_win();
    endtask

    task automatic at_posedge();
        model_edge(exp_win);
        @(posedge Clk);
        #1;
    endtask

    task automatic run_cycle();
        at_negedge();
        at_posedge();
    endtask

    task automatic test_reset();
        Reset = 1'b0; AluReq = 1'b1;
        #12;
        model_reset();
        checks++; if (WriteEn !== 1'b0) begin errors++; $display("FAIL reset_we: got %0b want 0", WriteEn); end
        checks++; if (Waddr !== 3'd0) begin errors++; $display("FAIL reset_waddr: got %0d want 0", Waddr); end
        checks++; if (DataIn !== 8'd0) begin errors++; $display("FAIL reset_data: got %0h want 0", DataIn); end
        checks++; if (StallCnt !== 8'd0) begin errors++; $display("FAIL reset_stall: got %0d want 0", StallCnt); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL reset_busy: got %0b want 1", Busy); end
        checks++; if (gnt_v !== 3'b000) begin errors++; $display("FAIL reset_gnt: got %b want 000", gnt_v); end
        AluReq = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
    endtask

    task automatic test_sweep();
        for (int c = 0; c < NREG; c++) begin
            at_negedge();
            checks++; if (gnt_v !== 3'b000) begin errors++; $display("FAIL sweep_gnt[%0d]: got %b want 000", c, gnt_v); end
            at_posedge();
            checks++; if (WriteEn !== 1'b1 || Waddr !== 3'(c) || DataIn !== 8'd0)
                begin errors++; $display("FAIL sweep_write[%0d]: got we=%0b a=%0d d=%0h want we=1 a=%0d d=0", c, WriteEn, Waddr, DataIn, c); end
            checks++; if (Busy !== 1'(c < NREG - 1)) begin errors++; $display("FAIL sweep_busy[%0d]: got %0b want %0b", c, Busy, c < NREG - 1); end
        end
        run_cycle();
        checks++; if (WriteEn !== 1'b0 || Waddr !== 3'd7)
            begin errors++; $display("FAIL sweep_idle: got we=%0b a=%0d want we=0 a=7", WriteEn, Waddr); end
    endtask

    task automatic test_alu_single();
        AluReq = 1'b1; AluAddr = 3'd3; AluData = 8'h5A;
        at_negedge();
        checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL alu_gnt: got %b want 001", gnt_v); end
        at_posedge();
        AluReq = 1'b0;
        checks++; if (WriteEn !== 1'b1 || Waddr !== 3'd3 || DataIn !== 8'h5A)
            begin errors++; $display("FAIL alu_write: got we=%0b a=%0d d=%0h want we=1 a=3 d=5a", WriteEn, Waddr, DataIn); end
        at_negedge();
        checks++; if (gnt_v !== 3'b000) begin errors++; $display("FAIL alu_nogrant: got %b want 000", gnt_v); end
        at_posedge();
        checks++; if (WriteEn !== 1'b0 || Waddr !== 3'd3)
            begin errors++; $display("FAIL alu_after: got we=%0b a=%0d want we=0 a=3", WriteEn, Waddr); end
    endtask

    task automatic test_lut_mem();
        MemReq = 1'b1; MemAddr = 3'd1; MemData = 8'h22;
        run_cycle();
        MemReq = 1'b0;
        LutReq = 1'b1; LutData = 8'h11;
        MemReq = 1'b1; MemAddr = 3'd2; MemData = 8'h33;
        at_negedge();
        checks++; if (gnt_v !== 3'b100) begin errors++; $display("FAIL lutmem_gnt1: got %b want 100", gnt_v); end
        at_posedge();
        LutReq = 1'b0;
        checks++; if (WriteEn !== 1'b1 || Waddr !== 3'd7 || DataIn !== 8'h11)
            begin errors++; $display("FAIL lutmem_w1: got we=%0b a=%0d d=%0h want we=1 a=7 d=11", WriteEn, Waddr, DataIn); end
        at_negedge();
        checks++; if (gnt_v !== 3'b010) begin errors++; $display("FAIL lutmem_gnt2: got %b want 010", gnt_v); end
        at_posedge();
        MemReq = 1'b0;
        checks++; if (WriteEn !== 1'b1 || Waddr !== 3'd2 || DataIn !== 8'h33)
            begin errors++; $display("FAIL lutmem_w2: got we=%0b a=%0d d=%0h want we=1 a=2 d=33", WriteEn, Waddr, DataIn); end
    endtask

    task automatic test_round_robin();
        int s0, ea, ed, w;
        LutReq = 1'b1; LutData = 8'h00;
        run_cycle();
        s0 = m_stall;
        AluReq = 1'b1; AluAddr = 3'($urandom_range(0, 6)); AluData = 8'($urandom);
        MemReq = 1'b1; MemAddr = 3'($urandom_range(0, 6)); MemData = 8'($urandom);
        LutReq = 1'b1; LutData = 8'($urandom);
        for (int c = 0; c < 6; c++) begin
            w = c % 3;
            ea = (w == 0) ? int'(AluAddr) : (w == 1) ? int'(MemAddr) : 7;
            ed = (w == 0) ? int'(AluData) : (w == 1) ? int'(MemData) : int'(LutData);
            at_negedge();
            checks++; if (gnt_v !== win_vec(w)) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, gnt_v, win_vec(w)); end
            at_posedge();
            checks++; if (WriteEn !== 1'b1 || Waddr !== 3'(ea) || DataIn !== 8'(ed))
                begin errors++; $display("FAIL rr_write[%0d]: got a=%0d d=%0h want a=%0d d=%0h", c, Waddr, DataIn, ea, ed); end
            case (w)
                0: begin AluAddr = 3'($urandom_range(0, 6)); AluData = 8'($urandom); end
                1: begin MemAddr = 3'($urandom_range(0, 6)); MemData = 8'($urandom); end
                default: LutData = 8'($urandom);
            endcase
        end
        AluReq = 1'b0; MemReq = 1'b0; LutReq = 1'b0;
        checks++; if (StallCnt !== 8'(s0 + 6)) begin errors++; $display("FAIL rr_stall: got %0d want %0d", StallCnt, s0 + 6); end
    endtask

    task automatic test_clear_req();
        ClearReq = 1'b1; AluReq = 1'b1; AluAddr = 3'd5; AluData = 8'h77;
        at_negedge();
        checks++; if (gnt_v !== 3'b000 || Busy !== 1'b0)
            begin errors++; $display("FAIL clr_gnt: got gnt=%b busy=%0b want gnt=000 busy=0", gnt_v, Busy); end
        at_posedge();
        ClearReq = 1'b0;
        checks++; if (WriteEn !== 1'b0 || Busy !== 1'b1)
            begin errors++; $display("FAIL clr_gap: got we=%0b busy=%0b want we=0 busy=1", WriteEn, Busy); end
        for (int c = 0; c < NREG; c++) begin
            at_negedge();
            checks++; if (gnt_v !== 3'b000) begin errors++; $display("FAIL clr_sweep_gnt[%0d]: got %b want 000", c, gnt_v); end
            at_posedge();
            checks++; if (WriteEn !== 1'b1 || Waddr !== 3'(c) || DataIn !== 8'd0 || Busy !== 1'(c < NREG - 1))
                begin errors++; $display("FAIL clr_sweep[%0d]: got we=%0b a=%0d d=%0h busy=%0b", c, WriteEn, Waddr, DataIn, Busy); end
        end
        at_negedge();
        checks++; if (gnt_v !== 3'b001) begin errors++; $display("FAIL clr_first_gnt: got %b want 001", gnt_v); end
        at_posedge();
        AluReq = 1'b0;
        checks++; if (WriteEn !== 1'b1 || Waddr !== 3'd5 || DataIn !== 8'h77)
            begin errors++; $display("FAIL clr_alu_write: got we=%0b a=%0d d=%0h want we=1 a=5 d=77", WriteEn, Waddr, DataIn); end
    endtask

    task automatic test_reset_mid_sweep();
        AluReq = 1'b1; AluAddr = 3'd1; AluData = 8'h99;
        Reset = 1'b0;
        model_reset();
        @(posedge Clk);
        #1 Reset = 1'b1;
        for (int c = 0; c < 4; c++) run_cycle();
        checks++; if (StallCnt !== 8'd4 || Waddr !== 3'd3)
            begin errors++; $display("FAIL mid_pre: got stall=%0d a=%0d want stall=4 a=3", StallCnt, Waddr); end
        #1 Reset = 1'b0;
        #1;
        model_reset();
        checks++; if (WriteEn !== 1'b0 || StallCnt !== 8'd0 || Busy !== 1'b1 || Waddr !== 3'd0)
            begin errors++; $display("FAIL mid_async: got we=%0b stall=%0d busy=%0b a=%0d", WriteEn, StallCnt, Busy, Waddr); end
        AluReq = 1'b0;
        @(posedge Clk);
        #1 Reset = 1'b1;
        run_cycle();
        checks++; if (WriteEn !== 1'b1 || Waddr !== 3'd0 || StallCnt !== 8'd0)
            begin errors++; $display("FAIL mid_restart: got we=%0b a=%0d stall=%0d want 1/0/0", WriteEn, Waddr, StallCnt); end
    endtask

    task automatic test_random();
        int lw = -1;
        for (int n = 0; n < 600; n++) begin
            if (lw == 0) begin
                if ($urandom_range(0, 1) == 0) AluReq = 1'b0;
                else begin AluAddr = 3'($urandom); AluData = 8'($urandom); end
            end else if (!AluReq && $urandom_range(0, 3) != 0) begin
                AluReq = 1'b1; AluAddr = 3'($urandom); AluData = 8'($urandom);
            end
            if (lw == 1) begin
                if ($urandom_range(0, 1) == 0) MemReq = 1'b0;
                else begin MemAddr = 3'($urandom); MemData = 8'($urandom); end
            end else if (!MemReq && $urandom_range(0, 3) != 0) begin
                MemReq = 1'b1; MemAddr = 3'($urandom); MemData = 8'($urandom);
            end
            if (lw == 2) begin
                if ($urandom_range(0, 1) == 0) LutReq = 1'b0;
                else LutData = 8'($urandom);
            end else if (!LutReq && $urandom_range(0, 3) != 0) begin
                LutReq = 1'b1; LutData = 8'($urandom);
            end
            ClearReq = ($urandom_range(0, 39) == 0);
            at_negedge();
            lw = exp_win;
            checks++; if (gnt_v !== win_vec(exp_win) || Busy !== 1'(m_busy))
                begin errors++; $display("FAIL rnd_gnt[%0d]: got gnt=%b busy=%0b want gnt=%b busy=%0d", n, gnt_v, Busy, win_vec(exp_win), m_busy); end
            at_posedge();
            checks++; if (WriteEn !== 1'(m_we) || Waddr !== 3'(m_waddr) || DataIn !== 8'(m_data))
                begin errors++; $display("FAIL rnd_write[%0d]: got we=%0b a=%0d d=%0h want we=%0d a=%0d d=%0h", n, WriteEn, Waddr, DataIn, m_we, m_waddr, m_data); end
            checks++; if (StallCnt !== 8'(m_stall))
                begin errors++; $display("FAIL rnd_stall[%0d]: got %0d want %0d", n, StallCnt, m_stall); end
        end
        ClearReq = 1'b0; AluReq = 1'b0; MemReq = 1'b0; LutReq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        Reset = 1'b0; ClearReq = 1'b0;
        AluReq = 1'b0; AluAddr = '0; AluData = '0;
        MemReq = 1'b0; MemAddr = '0; MemData = '0;
        LutReq = 1'b0; LutData = '0;
        exp_win = -1;
        model_reset();
        test_reset();
        test_sweep();
        test_alu_single();
        test_lut_mem();
        test_round_robin();
        test_clear_req();
        test_reset_mid_sweep();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
